// File: rtl/piradip_iq_capture_sequencer_pkg.sv
// Shared types for the IQ capture sequencer: FSM state encoding and the
// two-lane enable mode latched at the start of a run.
package piradip_iq_seq_pkg;

   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_ARM   = 3'd1,
      ST_RUN   = 3'd2,
      ST_DRAIN = 3'd3,
      ST_DONE  = 3'd4
   } seq_state_t;

   typedef struct packed {
      logic i_en;
      logic q_en;
   } lane_mode_t;

   localparam lane_mode_t LANE_OFF = '{i_en: 1'b0, q_en: 1'b0};

   // A run needs at least one lane enabled to produce any beats.
   function automatic logic lane_any(input lane_mode_t m);
      return (m != LANE_OFF);
   endfunction

endpackage

// File: rtl/piradip_iq_capture_sequencer_beat_counter.sv
// Saturating beat counter with terminal compare. o_last flags count = N-1,
// o_hit flags the increment that brings the count to N (N = 0 never hits).
module piradip_beat_counter #(
   parameter int WIDTH = 32
)(
   input  logic             i_clk,
   input  logic             i_rst,
   input  logic             i_clear,
   input  logic             i_inc,
   input  logic [WIDTH-1:0] i_terminal,
   output logic [WIDTH-1:0] o_count,
   output logic             o_last,
   output logic             o_hit
);

   logic [WIDTH-1:0] r_count;
   logic             w_sat;

   assign w_sat   = (r_count == {WIDTH{1'b1}});
   assign o_count = r_count;
   assign o_last  = (i_terminal != '0) && (r_count == (i_terminal - WIDTH'(1)));
   assign o_hit   = o_last && i_inc;

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         r_count <= '0;
      end else if (i_clear) begin
         r_count <= '0;
      end else if (i_inc && !w_sat) begin
         r_count <= r_count + WIDTH'(1);
      end
   end

endmodule

// File: rtl/piradip_iq_capture_sequencer.sv
// Run controller for the IQ interleaver: latches lane mode, optionally waits
// for a trigger, gates the lane enables and counts monitored output beats.
module piradip_iq_capture_sequencer
   import piradip_iq_seq_pkg::*;
#(
   parameter int COUNT_WIDTH  = 32,
   parameter int DRAIN_CYCLES = 2
)(
   input  logic                   aclk,
   input  logic                   areset,
   input  logic                   start,
   input  logic                   stop,
   input  logic                   cfg_i_en,
   input  logic                   cfg_q_en,
   input  logic [COUNT_WIDTH-1:0] cfg_beats,
   input  logic                   cfg_trig_en,
   input  logic                   trigger,
   input  logic                   mon_tvalid,
   input  logic                   mon_tready,
   output logic                   i_en,
   output logic                   q_en,
   output logic                   tlast,
   output logic                   busy,
   output logic                   done,
   output logic [COUNT_WIDTH-1:0] beats_done,
   output logic                   err_start,
   output logic                   overrun,
   output seq_state_t             o_dbg_state
);

   // Handshake semantics: a beat transfers on any cycle where mon_tvalid and
   // mon_tready are both high; this block only observes, it never stalls.

   localparam int DW             = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;
   localparam int DRAIN_LAST_INT = (DRAIN_CYCLES > 0) ? DRAIN_CYCLES - 1 : 0;
   localparam logic [DW-1:0] DRAIN_LAST = DRAIN_LAST_INT[DW-1:0];

   seq_state_t             r_state;
   lane_mode_t             r_mode;
   logic                   r_trig_en;
   logic [COUNT_WIDTH-1:0] r_beats;
   logic                   r_i_en;
   logic                   r_q_en;
   logic                   r_busy;
   logic                   r_done;
   logic                   r_err_start;
   logic                   r_overrun;
   logic [DW-1:0]          r_drain_cnt;

   lane_mode_t             w_cfg_mode;
   logic                   w_cfg_ok;
   logic                   w_handshake;
   logic                   w_start_accept;
   logic                   w_count_beat;
   logic [COUNT_WIDTH-1:0] w_count;
   logic                   w_last;
   logic                   w_hit;

   assign w_cfg_mode     = '{i_en: cfg_i_en, q_en: cfg_q_en};
   assign w_cfg_ok       = lane_any(w_cfg_mode);
   assign w_handshake    = mon_tvalid && mon_tready;
   assign w_start_accept = start && w_cfg_ok &&
                           ((r_state == ST_IDLE) || (r_state == ST_DONE));
   assign w_count_beat   = (r_state == ST_RUN) && w_handshake;

   piradip_beat_counter #(
      .WIDTH (COUNT_WIDTH)
   ) u_beat_counter (
      .i_clk      (aclk),
      .i_rst      (areset),
      .i_clear    (w_start_accept),
      .i_inc      (w_count_beat),
      .i_terminal (r_beats),
      .o_count    (w_count),
      .o_last     (w_last),
      .o_hit      (w_hit)
   );

   always_ff @(posedge aclk or posedge areset) begin
      if (areset) begin
         r_state     <= ST_IDLE;
         r_mode      <= LANE_OFF;
         r_trig_en   <= 1'b0;
         r_beats     <= '0;
         r_i_en      <= 1'b0;
         r_q_en      <= 1'b0;
         r_busy      <= 1'b0;
         r_done      <= 1'b0;
         r_err_start <= 1'b0;
         r_overrun   <= 1'b0;
         r_drain_cnt <= '0;
      end else begin
         r_err_start <= 1'b0;
         case (r_state)
            ST_IDLE, ST_DONE: begin
               if (w_start_accept) begin
                  r_mode    <= w_cfg_mode;
                  r_trig_en <= cfg_trig_en;
                  r_beats   <= cfg_beats;
                  r_done    <= 1'b0;
                  r_overrun <= 1'b0;
                  r_busy    <= 1'b1;
                  r_state   <= ST_ARM;
               end else if (start) begin
                  r_err_start <= 1'b1;
               end
            end

            ST_ARM: begin
               if (start) begin
                  r_err_start <= 1'b1;
               end
               if (stop) begin
                  r_drain_cnt <= '0;
                  r_state     <= ST_DRAIN;
               end else if (!r_trig_en || trigger) begin
                  r_i_en  <= r_mode.i_en;
                  r_q_en  <= r_mode.q_en;
                  r_state <= ST_RUN;
               end
            end

            ST_RUN: begin
               if (start) begin
                  r_err_start <= 1'b1;
               end
               // A beat on the same cycle as stop is still counted by the counter.
               if (stop || w_hit) begin
                  r_i_en      <= 1'b0;
                  r_q_en      <= 1'b0;
                  r_drain_cnt <= '0;
                  r_state     <= ST_DRAIN;
               end
            end

            ST_DRAIN: begin
               if (start) begin
                  r_err_start <= 1'b1;
               end
               if (w_handshake) begin
                  r_overrun <= 1'b1;
               end
               if (r_drain_cnt == DRAIN_LAST) begin
                  r_busy  <= 1'b0;
                  r_done  <= 1'b1;
                  r_state <= ST_DONE;
               end else begin
                  r_drain_cnt <= r_drain_cnt + DW'(1);
               end
            end

            default: begin
               r_i_en  <= 1'b0;
               r_q_en  <= 1'b0;
               r_busy  <= 1'b0;
               r_state <= ST_IDLE;
            end
         endcase
      end
   end

   assign i_en        = r_i_en;
   assign q_en        = r_q_en;
   assign tlast       = (r_state == ST_RUN) && w_last;
   assign busy        = r_busy;
   assign done        = r_done;
   assign beats_done  = w_count;
   assign err_start   = r_err_start;
   assign overrun     = r_overrun;
   assign o_dbg_state = r_state;

endmodule

// File: doc/piradip_iq_capture_sequencer.md
# piradip_iq_capture_sequencer

Run controller for the IQ sample interleaver. It latches a lane mode, optionally waits for an external trigger, and then drives the interleaver's `i_en`/`q_en`. It counts accepted output beats, asserts `tlast` on the final beat and reports completion. It sits between the register block (software start/stop/config) and the interleaver's enable inputs, and passively monitors the interleaver output handshake.

## Interface
Parameters:
- `COUNT_WIDTH`, 32: width of beat counters.
- `DRAIN_CYCLES`, 2: idle cycles after enables drop before `done`; covers the interleaver output register.

Ports:
- `aclk`  in  1  clock.
- `areset`  in  1  reset, asynchronous, active-high.
- `start`  in  1  single-cycle run request.
- `stop`  in  1  single-cycle abort.
- `cfg_i_en`, `cfg_q_en`  in  1 each  lane mode, sampled on accepted `start`.
- `cfg_beats`  in  COUNT_WIDTH  output beats per run; 0 = continuous until `stop`.
- `cfg_trig_en`  in  1  wait for `trigger` before running; sampled on `start`.
- `trigger`  in  1  external trigger, level, sampled in ARM.
- `mon_tvalid`, `mon_tready`  in  1 each  interleaver output handshake monitor.
- `i_en`, `q_en`  out  1 each  interleaver enables.
- `tlast`  out  1  final-beat marker, aligned with the monitored stream.
- `busy`  out  1  state ≠ IDLE and ≠ DONE.
- `done`  out  1  sticky, cleared by next accepted `start`.
- `beats_done`  out  COUNT_WIDTH  beats accepted in current/last run.
- `err_start`  out  1  one-cycle pulse on a rejected `start`.
- `overrun`  out  1  sticky; a handshake occurred in DRAIN; cleared on accepted `start`.

## Operation
- States: IDLE, ARM, RUN, DRAIN, DONE.
- `start` is accepted in IDLE or DONE with mode ≠ 00. An accepted `start` latches cfg, clears `beats_done`, `done` and `overrun`, and enters ARM.
- `start` is rejected in ARM/RUN/DRAIN, or when mode = 00. A rejected `start` pulses `err_start` with no state change.
- ARM: if the latched `trig_en`=0, go to RUN next cycle. Otherwise stay until `trigger`=1, then go to RUN.
- RUN: `i_en`/`q_en` equal the latched mode. A handshake is `mon_tvalid & mon_tready`; each one increments `beats_done`.
  - With `cfg_beats`=N>0, the handshake that makes `beats_done`=N moves to DRAIN.
  - With N=0, `beats_done` saturates at all-ones.
- DRAIN: enables = 0. Count DRAIN_CYCLES cycles, then go to DONE with `done`=1. Handshakes in DRAIN are not counted and set `overrun`.
- `stop` in ARM or RUN goes to DRAIN. `stop` in IDLE/DONE/DRAIN is ignored. `stop` beats `start` in the same cycle.
- `tlast` = RUN & (N>0) & (`beats_done` = N−1); it is meaningful only when qualified by the handshake.
- In all states except RUN, `i_en`=`q_en`=0.
- Reset (any state, including mid-run): IDLE. All outputs 0, counters 0, latched cfg 0.

## Timing
- `i_en`, `q_en`, `busy`, `done`, `err_start`, `overrun`, `beats_done` are registered. `tlast` is combinational from state and counter.
- Accepted `start` at cycle t with `trig_en`=0: ARM at t+1; RUN with enables high at t+2.
- With `trig_en`=1: RUN begins the cycle after `trigger` is sampled high in ARM.
- Final handshake at cycle t: DRAIN and enables low at t+1; `done`=1 at t+1+DRAIN_CYCLES.
- `beats_done` updates the cycle after each handshake.
- N=1: `tlast` is high from RUN entry.

## Structure
- Package `piradip_iq_seq_pkg`:
  - `seq_state_t` enum (IDLE, ARM, RUN, DRAIN, DONE).
  - `lane_mode_t` packed {i_en, q_en}.
  - Constant `LANE_OFF`.
- Sub-module `piradip_beat_counter`: clear, increment, saturate, terminal-compare vs N with `last` and `hit` outputs. Used for the beat count; the drain timer is inline.

## Test plan
- Mode 11, N=4, no trigger, `mon_tready`=1: enables high at t+2; exactly 4 counted beats; `tlast` on the 4th; `done` at final+1+2; `beats_done`=4.
- Mode 10, `trig_en`=1, `trigger` pulsed 20 cycles after `start`: enables stay 0 through ARM, and `i_en`=1 with `q_en`=0 the cycle after the trigger.
- N=8, `mon_tready` toggling with 50% backpressure: counts only handshakes; `tlast` on the 8th; `beats_done`=8.
- N=0 continuous, `stop` after 100 beats: DRAIN then `done`; `beats_done`=100; `tlast` never asserts.
- `start` while RUN, and `start` with mode 00 in IDLE: `err_start` pulses, state unchanged. A beat forced during DRAIN sets `overrun`.
- `areset` asserted mid-RUN: immediate IDLE, all outputs 0. A following `start` runs normally.
